// File: rtl/sig_addsub_pipe.sv
// ============================================================================
// sig_addsub_pipe
// ----------------------------------------------------------------------------
// Two-stage pipelined significand adder/subtractor for the floating-point
// datapath. Computes (+/-A) + (+/-B) on unsigned W-bit significands and
// returns the result in sign-magnitude form. It accepts one operation per
// cycle and uses valid/ready flow control on both sides.
//
// Stage 1 holds the W+2 bit two's complement sum.
// Stage 2 holds the magnitude, the sign and the zero flag.
// All outputs come from stage 2 only, so they hold steady while the
// downstream side stalls.
//
// Optional feature macro: SIG_LZC_EN
//    defined   -> the lzc output exists. It is the leading-zero count of z
//                 from bit W downwards, derived combinationally from the
//                 stage 2 register.
//    undefined -> the lzc port and its logic are not built.
//
// Parameters:
//    W    significand width (4..64)
//    LZW  width of lzc, derived from W (present only with SIG_LZC_EN)
//
// Ports:
//    clk        clock, rising edge
//    rst_n      asynchronous active-low reset
//    in_valid   operand set on a, b, op is valid
//    in_ready   block accepts the operand set this cycle
//    a, b       unsigned W-bit significands
//    op         op[0] negates A, op[1] negates B
//    out_valid  result fields are valid
//    out_ready  downstream accepts the result this cycle
//    z          result magnitude, W+1 bits
//    sign       result sign, 1 = negative
//    zero       result is exactly zero
//    lzc        leading zeros of z (SIG_LZC_EN only)
// ============================================================================
module sig_addsub_pipe #(
   parameter int W = 24
`ifdef SIG_LZC_EN
   ,
   localparam int LZW = $clog2(W + 2)
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       z,
   output logic             sign,
`ifdef SIG_LZC_EN
   output logic             zero,
   output logic [LZW-1:0]   lzc
`else
   output logic             zero
`endif
);

   localparam logic [W+1:0] ONE_SUM = (W + 2)'(1);
   localparam logic [W:0]   ONE_MAG = (W + 1)'(1);

   logic             v1;
   logic             v2;
   logic             s1_load;
   logic             s2_load;

   logic [W+1:0]     ext_a;
   logic [W+1:0]     ext_b;
   logic [W+1:0]     opnd_a;
   logic [W+1:0]     opnd_b;
   logic [W+1:0]     sum_d;
   logic [W+1:0]     s1_sum;

   logic [W:0]       neg_mag;
   logic [W:0]       z_d;
   logic             sign_d;
   logic             zero_d;

   logic [W:0]       s2_z;
   logic             s2_sign;
   logic             s2_zero;

   // Handshake decode. Stage 2 takes stage 1 whenever stage 2 is empty or is
   // draining this cycle. Stage 1 can accept when it is empty or is moving
   // into stage 2. This lets a full pipe accept and drain in the same cycle,
   // so there are no bubbles while out_ready stays high.
   always_comb begin
      s2_load  = v1 && (!v2 || out_ready);
      in_ready = !v1 || s2_load;
      s1_load  = in_valid && in_ready;
   end

   // Stage occupancy bits. Reset is asynchronous, so anything in flight is
   // dropped the moment rst_n falls, even in the middle of a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= s1_load || (v1 && !s2_load);
         if (s2_load) begin
            v2 <= 1'b1;
         end else if (out_ready) begin
            v2 <= 1'b0;
         end
      end
   end

   // Stage 1 operand conditioning and sum. Both operands are zero-extended to
   // W+2 bits and then negated as true two's complement (invert plus one).
   // When both are negated the result is exactly -(A+B). The widest result,
   // 2^(W+1)-2, needs W+1 magnitude bits plus a sign bit, which is why the
   // sum is W+2 bits wide.
   always_comb begin
      ext_a  = {2'b00, a};
      ext_b  = {2'b00, b};
      opnd_a = op[0] ? (~ext_a + ONE_SUM) : ext_a;
      opnd_b = op[1] ? (~ext_b + ONE_SUM) : ext_b;
      sum_d  = opnd_a + opnd_b;
   end

   // Stage 1 data register. It only loads on an accepted operand, so a
   // stalled entry is never overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum <= '0;
      end else if (s1_load) begin
         s1_sum <= sum_d;
      end
   end

   // Stage 2 sign-magnitude conversion. |sum| always fits in W+1 bits, so
   // the magnitude can be negated modulo 2^(W+1) on the low bits alone. A
   // zero sum already has a clear top bit. The explicit zero term keeps the
   // sign at 0 regardless.
   always_comb begin
      neg_mag = ~s1_sum[W:0] + ONE_MAG;
      zero_d  = (s1_sum == '0);
      sign_d  = s1_sum[W+1] && !zero_d;
      z_d     = s1_sum[W+1] ? neg_mag : s1_sum[W:0];
   end

   // Stage 2 data register. It holds while the downstream side stalls, which
   // keeps every output stable until it is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_z    <= '0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
      end else if (s2_load) begin
         s2_z    <= z_d;
         s2_sign <= sign_d;
         s2_zero <= zero_d;
      end
   end

   // Outputs come straight from the stage 2 register.
   always_comb begin
      out_valid = v2;
      z         = s2_z;
      sign      = s2_sign;
      zero      = s2_zero;
   end

`ifdef SIG_LZC_EN
   logic [LZW-1:0] lzc_cnt;
   logic           lzc_found;

   // Leading-zero count of the registered magnitude, scanned from bit W
   // downwards. An all-zero magnitude gives W+1. The count is forced to 0
   // while the output is not valid, so lzc reads 0 after reset like the
   // other result fields.
   always_comb begin
      lzc_cnt   = LZW'(W + 1);
      lzc_found = 1'b0;
      for (int i = W; i >= 0; i--) begin
         if (!lzc_found && s2_z[i]) begin
            lzc_cnt   = LZW'(W - i);
            lzc_found = 1'b1;
         end
      end
      lzc = v2 ? lzc_cnt : '0;
   end
`endif

endmodule

// File: tb/tb_sig_addsub_pipe.sv
// ============================================================================
// tb_sig_addsub_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for sig_addsub_pipe at W=24.
//
// Expected results are pushed to a scoreboard queue when an operand is
// accepted. They are popped and compared when the DUT hands a result
// downstream.
//
// Expected values come from two sources:
//    - a vector table holding hand-derived constants, and
//    - a signed-integer reference model for the random entries.
//
// Hand-written sequences cover:
//    - back-to-back streaming with a stall,
//    - reset asserted while both stages are full,
//    - pipeline latency.
//
// The lzc checks are built only when SIG_LZC_EN is defined.
// ============================================================================
module tb_sig_addsub_pipe;

   localparam int W    = 24;
   localparam int LZW  = $clog2(W + 2);
   localparam int NVEC = 16;

   typedef struct {
      logic [W:0]     z;
      logic           sign;
      logic           zero;
      logic [LZW-1:0] lzc;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      exp_t         e;
   } vec_t;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [1:0]     op;
   logic           out_valid;
   logic           out_ready;
   logic [W:0]     z;
   logic           sign;
   logic           zero;
`ifdef SIG_LZC_EN
   logic [LZW-1:0] lzc;
`endif

   int             compared;
   int             mismatched;
   exp_t           sb[$];
   vec_t           vecs[NVEC];

   logic           stalled_prev;
   logic [W:0]     held_z;
   logic           held_sign;
   logic           held_zero;

   sig_addsub_pipe #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .sign      (sign),
`ifdef SIG_LZC_EN
      .zero      (zero),
      .lzc       (lzc)
`else
      .zero      (zero)
`endif
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends, even if the DUT locks up.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model. It evaluates the operation in signed 64-bit integer
   // arithmetic and derives the sign-magnitude result and the leading-zero
   // count from that.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [1:0] mop);
      exp_t   r;
      longint sa;
      longint sbv;
      longint s;
      longint mag;
      sa     = mop[0] ? -longint'(ma) : longint'(ma);
      sbv    = mop[1] ? -longint'(mb) : longint'(mb);
      s      = sa + sbv;
      mag    = (s < 0) ? -s : s;
      r.z    = mag[W:0];
      r.sign = (s < 0);
      r.zero = (s == 0);
      r.lzc  = LZW'(W + 1);
      for (int i = 0; i <= W; i++) begin
         if (mag[i]) r.lzc = LZW'(W - i);
      end
      return r;
   endfunction

   // Single comparison point. Every check goes through here and steps the
   // counters.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one operand set and waits, with a bound, for it to be accepted.
   // On acceptance the expected result goes onto the scoreboard. Call this
   // just after a rising edge.
   task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] sbv,
                                input logic [1:0] sop, input exp_t e);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      a        = sa;
      b        = sbv;
      op       = sop;
      for (int c = 0; c < 100 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   // Waits, with a bound, until every expected result has been consumed.
   task automatic drain();
      for (int c = 0; c < 100 && sb.size() != 0; c++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor. A transfer happens at the next rising edge when
   // out_valid and out_ready are both high, so that result is compared
   // against the head of the scoreboard. It also checks that a stalled
   // result does not change until it is consumed.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled_prev <= 1'b0;
      end else begin
         if (stalled_prev) begin
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_z", 64'(z), 64'(held_z));
            checkOutput("stall_sign", 64'(sign), 64'(held_sign));
            checkOutput("stall_zero", 64'(zero), 64'(held_zero));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("z", 64'(z), 64'(e.z));
               checkOutput("sign", 64'(sign), 64'(e.sign));
               checkOutput("zero", 64'(zero), 64'(e.zero));
`ifdef SIG_LZC_EN
               checkOutput("lzc", 64'(lzc), 64'(e.lzc));
`endif
            end
         end
         stalled_prev <= out_valid && !out_ready;
         held_z       <= z;
         held_sign    <= sign;
         held_zero    <= zero;
      end
   end

   initial begin
      exp_t e;
      compared     = 0;
      mismatched   = 0;
      stalled_prev = 1'b0;
      held_z       = '0;
      held_sign    = 1'b0;
      held_zero    = 1'b0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      a            = '0;
      b            = '0;
      op           = 2'b00;
      out_ready    = 1'b1;

      // Vector table. The hand-derived entries cover the signed cases and the
      // zero and full-scale boundaries. The tail is random and is checked
      // through the model.
      vecs[0]  = '{24'h800000, 24'h400000, 2'b00, '{25'h0C00000, 1'b0, 1'b0, LZW'(1)}};
      vecs[1]  = '{24'h800000, 24'h400000, 2'b01, '{25'h0400000, 1'b1, 1'b0, LZW'(2)}};
      vecs[2]  = '{24'h800000, 24'h400000, 2'b10, '{25'h0400000, 1'b0, 1'b0, LZW'(2)}};
      vecs[3]  = '{24'hFFFFFF, 24'hFFFFFF, 2'b11, '{25'h1FFFFFE, 1'b1, 1'b0, LZW'(0)}};
      vecs[4]  = '{24'h123456, 24'h123456, 2'b01, '{25'h0000000, 1'b0, 1'b1, LZW'(25)}};
      vecs[5]  = '{24'hFFFFFF, 24'hFFFFFF, 2'b00, '{25'h1FFFFFE, 1'b0, 1'b0, LZW'(0)}};
      vecs[6]  = '{24'h000000, 24'h000000, 2'b00, '{25'h0000000, 1'b0, 1'b1, LZW'(25)}};
      vecs[7]  = '{24'h000000, 24'h000001, 2'b10, '{25'h0000001, 1'b1, 1'b0, LZW'(24)}};
      vecs[8]  = '{24'h000000, 24'h000000, 2'b11, '{25'h0000000, 1'b0, 1'b1, LZW'(25)}};
      vecs[9]  = '{24'hFFFFFF, 24'h000000, 2'b10, '{25'h0FFFFFF, 1'b0, 1'b0, LZW'(1)}};
      for (int i = 10; i < NVEC; i++) begin
         vecs[i].a  = W'($urandom);
         vecs[i].b  = W'($urandom);
         vecs[i].op = 2'($urandom_range(0, 3));
         vecs[i].e  = model(vecs[i].a, vecs[i].b, vecs[i].op);
      end

      // Reset state: outputs cleared, in_ready high once released.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_z", 64'(z), 64'd0);
      checkOutput("rst_sign", 64'(sign), 64'd0);
      checkOutput("rst_zero", 64'(zero), 64'd0);
`ifdef SIG_LZC_EN
      checkOutput("rst_lzc", 64'(lzc), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

      // Table vectors streamed back to back with out_ready held high.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
      end
      drain();

      // Five ops streamed with out_ready low for three cycles. The control
      // thread checks that in_ready drops while both stages are occupied.
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               logic [W-1:0] ra;
               logic [W-1:0] rb;
               logic [1:0]   rop;
               ra  = W'($urandom);
               rb  = W'($urandom);
               rop = 2'(i);
               applyStimulus(ra, rb, rop, model(ra, rb, rop));
            end
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Fill both stages under a stall, then reset mid-stall.
      out_ready = 1'b0;
      applyStimulus(24'h0000AA, 24'h000055, 2'b00, model(24'h0000AA, 24'h000055, 2'b00));
      applyStimulus(24'h00F000, 24'h000F00, 2'b01, model(24'h00F000, 24'h000F00, 2'b01));
      @(negedge clk);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      checkOutput("full_out_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_z", 64'(z), 64'd0);
      checkOutput("midrst_sign", 64'(sign), 64'd0);
      checkOutput("midrst_zero", 64'(zero), 64'd0);
`ifdef SIG_LZC_EN
      checkOutput("midrst_lzc", 64'(lzc), 64'd0);
`endif
      sb.delete();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("held_rst_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First op after release. It is not visible after its accepting edge
      // and becomes visible after the following edge. The monitor checks
      // the value.
      e = model(24'hABCDEF, 24'h123456, 2'b10);
      applyStimulus(24'hABCDEF, 24'h123456, 2'b10, e);
      @(negedge clk);
      checkOutput("latency_s1", 64'(out_valid), 64'd0);
      @(negedge clk);
      checkOutput("latency_s2", 64'(out_valid), 64'd1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
